fc_layer_ctrl: RTL and testbench



---
 rtl/cnn_pkg.sv | 12 +
 rtl/fc_layer_ctrl_if.sv | 12 +
 rtl/mac_unit.sv | 15 +
 rtl/fc_layer_ctrl.sv | 76 +++++++
 tb/tb_fc_layer_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM encoding, Q-format constants and saturation helper for the CNN datapath
package cnn_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, MAC, SCALE, DONE} state_t;
   localparam int Q_FRAC = 12;
   localparam int Q_OUT_W = 16;
   function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int width);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      return v > hi ? hi : (v < lo ? lo : v);
   endfunction
endpackage

// File: rtl/fc_layer_ctrl_if.sv
// fc_layer_ctrl_if: feature handshake, weight write port and result bus of the FC sequencer
interface fc_layer_ctrl_if #(parameter int N_IN = 4, DW = 13, WW = 13, OUT_W = 16);
   logic start, feat_valid, feat_ready, wt_we, busy, out_valid, done;
   logic signed [DW-1:0] feat_data;
   logic [$clog2(N_IN)-1:0] wt_addr;
   logic signed [WW-1:0] wt_data;
   logic signed [OUT_W-1:0] out_data;
   modport master(output start, feat_valid, feat_data, wt_we, wt_addr, wt_data,
                  input feat_ready, busy, out_valid, out_data, done);
   modport slave(input start, feat_valid, feat_data, wt_we, wt_addr, wt_data,
                 output feat_ready, busy, out_valid, out_data, done);
endinterface

// File: rtl/mac_unit.sv
// mac_unit: registered signed multiply-accumulate with synchronous clear
module mac_unit #(parameter int DW = 13, WW = 13, ACC_W = 32) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [DW-1:0]    a,
   input  logic signed [WW-1:0]    b,
   output logic signed [ACC_W-1:0] acc
);
   always_ff @(posedge clk) begin
      if (rst || clr) acc <= '0;
      else if (en) acc <= acc + ACC_W'(a) * ACC_W'(b);
   end
endmodule

// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: fully-connected layer sequencer with a shared MAC and a run-time weight bank
module fc_layer_ctrl import cnn_pkg::*; #(
   parameter int N_IN = 4, DW = 13, WW = 13, ACC_W = 32, OUT_W = Q_OUT_W, FRAC = Q_FRAC
) (
   input logic clk,
   input logic rst,
   fc_layer_ctrl_if.slave bus
);
   localparam int AW = $clog2(N_IN);
   state_t state;
   logic [AW-1:0] cnt, idx;
   logic signed [DW-1:0] fbuf [N_IN];
   logic signed [WW-1:0] w [N_IN];
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W+FRAC-1:0] scaled;
   logic go;
   assign go = bus.start && (state == IDLE || state == DONE);
   assign scaled = (ACC_W+FRAC)'(acc) <<< FRAC;
   mac_unit #(.DW(DW), .WW(WW), .ACC_W(ACC_W)) u_mac (
      .clk(clk), .rst(rst), .clr(go), .en(state == MAC),
      .a(fbuf[idx]), .b(w[idx]), .acc(acc)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         bus.feat_ready <= 1'b0;
         bus.busy <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.done <= 1'b0;
         bus.out_data <= '0;
         for (int i = 0; i < N_IN; i++) begin
            w[i] <= i == 0 ? WW'(1) : '1;
            fbuf[i] <= '0;
         end
      end else begin
         bus.out_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // write precedes start so a same-edge write feeds this inference
               if (bus.wt_we && 32'(bus.wt_addr) < N_IN) w[bus.wt_addr] <= bus.wt_data;
               if (bus.start) begin
                  state <= LOAD;
                  cnt <= '0;
                  idx <= '0;
                  bus.feat_ready <= 1'b1;
                  bus.busy <= 1'b1;
                  bus.done <= 1'b0;
               end
            end
            LOAD: if (bus.feat_valid) begin
               fbuf[cnt] <= bus.feat_data;
               cnt <= cnt + 1'b1;
               if (cnt == AW'(N_IN - 1)) begin
                  state <= MAC;
                  idx <= '0;
                  bus.feat_ready <= 1'b0;
               end
            end
            MAC: begin
               idx <= idx + 1'b1;
               if (idx == AW'(N_IN - 1)) state <= SCALE;
            end
            SCALE: begin
               bus.out_data <= OUT_W'(sat_s(64'(scaled), OUT_W));
               bus.out_valid <= 1'b1;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: directed self-checking bench for the FC layer sequencer
module tb_fc_layer_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   fc_layer_ctrl_if bus();
   fc_layer_ctrl dut(.clk(clk), .rst(rst), .bus(bus));

   // poke: 0 none, 1 weight write during MAC, 2 start during MAC
   task automatic run(input logic signed [12:0] f0, f1, f2, f3, input int gap, input int poke,
                      output int lat, output logic signed [15:0] res, output int pb);
      logic signed [12:0] f [4];
      f = '{f0, f1, f2, f3};
      pb = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) pb++;
      for (int i = 0; i < 4; i++) begin
         repeat (gap) begin
            if (bus.feat_ready !== 1'b1) pb++;
            @(negedge clk);
         end
         if (bus.feat_ready !== 1'b1) pb++;
         bus.feat_valid = 1'b1;
         bus.feat_data = f[i];
         @(negedge clk);
         bus.feat_valid = 1'b0;
      end
      if (bus.feat_ready !== 1'b0) pb++;
      if (poke == 1) begin
         bus.wt_we = 1'b1;
         bus.wt_addr = 2'd1;
         bus.wt_data = 13'sd100;
      end
      if (poke == 2) bus.start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 2) begin
            bus.wt_we = 1'b0;
            bus.start = 1'b0;
         end
      end while (bus.out_valid !== 1'b1 && lat < 20);
      res = bus.out_data;
   endtask

   task automatic write_w(input logic [1:0] a, input logic signed [12:0] d);
      bus.wt_we = 1'b1;
      bus.wt_addr = a;
      bus.wt_data = d;
      @(negedge clk);
      bus.wt_we = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.feat_ready, bus.busy, bus.out_valid, bus.done} !== 4'b0 || bus.out_data !== 16'sd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got rdy/busy/ov/done=%b%b%b%b data=%0d, want 0000 data=0",
                  bus.feat_ready, bus.busy, bus.out_valid, bus.done, bus.out_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int lat, pb;
      logic signed [15:0] res;
      run(10, 2, 3, 4, 0, 0, lat, res, pb);
      n_cmp++;
      if (lat !== 5 || bus.out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d edges valid=%b, want 5 edges valid=1", lat, bus.out_valid);
      end
      n_cmp++;
      if (res !== 16'sd4096) begin
         n_bad++;
         $display("FAIL basic_data: got %0d, want 4096", res);
      end
      n_cmp++;
      if (pb !== 0) begin
         n_bad++;
         $display("FAIL basic_handshake: got %0d protocol errors, want 0", pb);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_data !== 16'sd4096) begin
         n_bad++;
         $display("FAIL basic_done: got ov=%b done=%b busy=%b data=%0d, want 0 1 0 4096",
                  bus.out_valid, bus.done, bus.busy, bus.out_data);
      end
   endtask

   task automatic test_saturation;
      int lat, pb;
      logic signed [15:0] res;
      run(8, 0, 0, 0, 0, 0, lat, res, pb);
      n_cmp++;
      if (res !== 16'sd32767 || lat !== 5) begin
         n_bad++;
         $display("FAIL sat_pos: got %0d after %0d edges, want 32767 after 5", res, lat);
      end
      n_cmp++;
      if (pb !== 0) begin
         n_bad++;
         $display("FAIL sat_pos_handshake: got %0d protocol errors, want 0", pb);
      end
      run(0, 3, 3, 3, 0, 0, lat, res, pb);
      n_cmp++;
      if (res !== -16'sd32768 || lat !== 5) begin
         n_bad++;
         $display("FAIL sat_neg: got %0d after %0d edges, want -32768 after 5", res, lat);
      end
      n_cmp++;
      if (pb !== 0) begin
         n_bad++;
         $display("FAIL sat_neg_handshake: got %0d protocol errors, want 0", pb);
      end
   endtask

   task automatic test_weight_write;
      int lat, pb;
      logic signed [15:0] res;
      write_w(2'd1, 13'sd2);
      run(1, 1, 0, 0, 0, 0, lat, res, pb);
      n_cmp++;
      if (res !== 16'sd12288) begin
         n_bad++;
         $display("FAIL wt_write: got %0d, want 12288", res);
      end
      run(1, 1, 0, 0, 0, 1, lat, res, pb);
      n_cmp++;
      if (res !== 16'sd12288 || lat !== 5) begin
         n_bad++;
         $display("FAIL wt_write_in_mac: got %0d after %0d edges, want 12288 after 5", res, lat);
      end
      @(negedge clk);
      write_w(2'd1, -13'sd1);
   endtask

   task automatic test_gapped;
      int lat, pb;
      logic signed [15:0] res;
      run(5, 5, 5, 5, 3, 0, lat, res, pb);
      n_cmp++;
      if (pb !== 0) begin
         n_bad++;
         $display("FAIL gapped_ready: got %0d protocol errors, want 0", pb);
      end
      n_cmp++;
      if (res !== -16'sd32768 || lat !== 5) begin
         n_bad++;
         $display("FAIL gapped_data: got %0d after %0d edges, want -32768 after 5", res, lat);
      end
   endtask

   task automatic test_reset_mid;
      int lat, pb, ov;
      logic signed [15:0] res;
      write_w(2'd0, 13'sd3);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.feat_valid = 1'b1;
      bus.feat_data = 13'sd7;
      repeat (2) @(negedge clk);
      bus.feat_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({bus.feat_ready, bus.busy, bus.out_valid, bus.done} !== 4'b0 || bus.out_data !== 16'sd0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got rdy/busy/ov/done=%b%b%b%b data=%0d, want 0000 data=0",
                  bus.feat_ready, bus.busy, bus.out_valid, bus.done, bus.out_data);
      end
      ov = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) ov++;
      end
      n_cmp++;
      if (ov !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_idle: got %0d active cycles after abort, want 0", ov);
      end
      run(10, 2, 3, 4, 0, 0, lat, res, pb);
      n_cmp++;
      if (res !== 16'sd4096 || lat !== 5) begin
         n_bad++;
         $display("FAIL rst_mid_weights: got %0d after %0d edges, want 4096 after 5", res, lat);
      end
   endtask

   task automatic test_start_in_mac;
      int lat, pb, extra;
      logic signed [15:0] res;
      @(negedge clk);
      run(10, 2, 3, 4, 0, 2, lat, res, pb);
      n_cmp++;
      if (res !== 16'sd4096 || lat !== 5) begin
         n_bad++;
         $display("FAIL start_mac_data: got %0d after %0d edges, want 4096 after 5", res, lat);
      end
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) extra++;
      end
      n_cmp++;
      if (extra !== 0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL start_mac_single: got %0d extra pulses done=%b busy=%b, want 0 1 0",
                  extra, bus.done, bus.busy);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.feat_valid = 1'b0;
      bus.feat_data = '0;
      bus.wt_we = 1'b0;
      bus.wt_addr = '0;
      bus.wt_data = '0;
      test_reset();
      test_basic();
      test_saturation();
      test_weight_write();
      test_gapped();
      test_reset_mid();
      test_start_in_mac();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
